mshr_entry_tracker: RTL and testbench

MSHR_ENTRY_TRACKER -- requirements
Module: mshr_entry_tracker

---
 rtl/mshr_entry_tracker.sv | 117 +++++++++++
 tb/tb_mshr_entry_tracker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_entry_tracker.sv
// Per-entry FREE/RSVD/BUSY tracker for MSHR slots; all state, counts and error pulses register in one cycle.
// No backpressure: v_free_vld is combinational from state, reservations, allocs and releases are accepted or flagged every cycle.
module mshr_entry_tracker #(
  parameter int ENTRY_NUM      = 32,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int CNT_WIDTH      = $clog2(ENTRY_NUM + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ENTRY_NUM-1:0]      v_free_vld,
  input  logic [ENTRY_NUM-1:0]      v_free_rdy,
  input  logic                      alloc_vld_0,
  input  logic [ENTRY_ID_WIDTH-1:0] alloc_idx_0,
  input  logic                      alloc_vld_1,
  input  logic [ENTRY_ID_WIDTH-1:0] alloc_idx_1,
  input  logic                      rel_vld_0,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx_0,
  input  logic                      rel_vld_1,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx_1,
  output logic [CNT_WIDTH-1:0]      free_cnt,
  output logic [CNT_WIDTH-1:0]      rsvd_cnt,
  output logic [CNT_WIDTH-1:0]      busy_cnt,
  output logic                      all_taken,
  output logic                      err_alloc,
  output logic                      err_rel
);

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_RSVD = 2'b01,
    ST_BUSY = 2'b10
  } ent_st_e;

  ent_st_e st_q [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] rsv_hit, a0_hit, a1_hit, r0_hit, r1_hit;
  logic [ENTRY_NUM-1:0] alloc_hit, rel_hit;
  logic                 dup_alloc, dup_rel;
  logic                 err_alloc_nxt, err_rel_nxt;
  logic [CNT_WIDTH-1:0] n_rsv, n_alloc, n_rel;
  logic [CNT_WIDTH-1:0] free_nxt, rsvd_nxt, busy_nxt;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      n = n + CNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  assign dup_alloc = alloc_vld_0 && (alloc_idx_0 == alloc_idx_1);
  assign dup_rel   = rel_vld_0 && (rel_idx_0 == rel_idx_1);

  // Index matching per entry means an out-of-range index simply never hits and falls out as an error.
  always_comb begin
    v_free_vld = '0;
    rsv_hit    = '0;
    a0_hit     = '0;
    a1_hit     = '0;
    r0_hit     = '0;
    r1_hit     = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      v_free_vld[i] = (st_q[i] == ST_FREE);
      rsv_hit[i]    = v_free_vld[i] && v_free_rdy[i];
      a0_hit[i]     = alloc_vld_0 && (alloc_idx_0 == ENTRY_ID_WIDTH'(i)) && (st_q[i] == ST_RSVD);
      a1_hit[i]     = alloc_vld_1 && !dup_alloc && (alloc_idx_1 == ENTRY_ID_WIDTH'(i)) &&
                      (st_q[i] == ST_RSVD);
      r0_hit[i]     = rel_vld_0 && (rel_idx_0 == ENTRY_ID_WIDTH'(i)) && (st_q[i] == ST_BUSY);
      r1_hit[i]     = rel_vld_1 && !dup_rel && (rel_idx_1 == ENTRY_ID_WIDTH'(i)) &&
                      (st_q[i] == ST_BUSY);
    end
  end

  assign alloc_hit     = a0_hit | a1_hit;
  assign rel_hit       = r0_hit | r1_hit;
  assign err_alloc_nxt = (alloc_vld_0 && !(|a0_hit)) || (alloc_vld_1 && !(|a1_hit));
  assign err_rel_nxt   = (rel_vld_0 && !(|r0_hit)) || (rel_vld_1 && !(|r1_hit));

  assign n_rsv    = popcnt(rsv_hit);
  assign n_alloc  = popcnt(alloc_hit);
  assign n_rel    = popcnt(rel_hit);
  assign free_nxt = free_cnt - n_rsv + n_rel;
  assign rsvd_nxt = rsvd_cnt + n_rsv - n_alloc;
  assign busy_nxt = busy_cnt + n_alloc - n_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i] <= ST_FREE;
      end
      free_cnt  <= CNT_WIDTH'(ENTRY_NUM);
      rsvd_cnt  <= '0;
      busy_cnt  <= '0;
      all_taken <= 1'b0;
      err_alloc <= 1'b0;
      err_rel   <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (rsv_hit[i]) begin
          st_q[i] <= ST_RSVD;
        end else if (alloc_hit[i]) begin
          st_q[i] <= ST_BUSY;
        end else if (rel_hit[i]) begin
          st_q[i] <= ST_FREE;
        end
      end
      free_cnt  <= free_nxt;
      rsvd_cnt  <= rsvd_nxt;
      busy_cnt  <= busy_nxt;
      all_taken <= (free_nxt == '0);
      err_alloc <= err_alloc_nxt;
      err_rel   <= err_rel_nxt;
    end
  end

endmodule

// File: tb/tb_mshr_entry_tracker.sv
// Directed bench for mshr_entry_tracker: hand-computed counts, state vectors and error pulses.
module tb_mshr_entry_tracker;
  localparam int N  = 32;
  localparam int IW = 5;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  v_free_vld;
  logic [N-1:0]  v_free_rdy;
  logic          alloc_vld_0, alloc_vld_1, rel_vld_0, rel_vld_1;
  logic [IW-1:0] alloc_idx_0, alloc_idx_1, rel_idx_0, rel_idx_1;
  logic [CW-1:0] free_cnt, rsvd_cnt, busy_cnt;
  logic          all_taken, err_alloc, err_rel;

  int checks = 0;
  int errors = 0;

  mshr_entry_tracker #(.ENTRY_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_free_vld(v_free_vld), .v_free_rdy(v_free_rdy),
    .alloc_vld_0(alloc_vld_0), .alloc_idx_0(alloc_idx_0),
    .alloc_vld_1(alloc_vld_1), .alloc_idx_1(alloc_idx_1),
    .rel_vld_0(rel_vld_0), .rel_idx_0(rel_idx_0),
    .rel_vld_1(rel_vld_1), .rel_idx_1(rel_idx_1),
    .free_cnt(free_cnt), .rsvd_cnt(rsvd_cnt), .busy_cnt(busy_cnt),
    .all_taken(all_taken), .err_alloc(err_alloc), .err_rel(err_rel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    v_free_rdy  = '0;
    alloc_vld_0 = 1'b0; alloc_idx_0 = '0;
    alloc_vld_1 = 1'b0; alloc_idx_1 = '0;
    rel_vld_0   = 1'b0; rel_idx_0   = '0;
    rel_vld_1   = 1'b0; rel_idx_1   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int f, input int r, input int b);
    chk({tag, "_free"}, 64'(free_cnt), 64'(f));
    chk({tag, "_rsvd"}, 64'(rsvd_cnt), 64'(r));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(b));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, 64'(v_free_vld), 64'hFFFF_FFFF);
    chk_cnt(tag, 32, 0, 0);
    chk({tag, "_taken"}, 64'(all_taken), 64'd0);
    chk({tag, "_erra"}, 64'(err_alloc), 64'd0);
    chk({tag, "_errr"}, 64'(err_rel), 64'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    chk_reset("rst_idle");

    // reserve 0,1 -> alloc both -> release 0
    v_free_rdy = 32'h3;
    tick();
    chk_cnt("rsv01", 30, 2, 0);
    chk("rsv01_vld", 64'(v_free_vld), 64'hFFFF_FFFC);
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd0;
    alloc_vld_1 = 1'b1; alloc_idx_1 = 5'd1;
    tick();
    chk_cnt("alloc01", 30, 0, 2);
    chk("alloc01_erra", 64'(err_alloc), 64'd0);
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd0;
    chk("rel0_nobypass", 64'(v_free_vld[0]), 64'd0);
    tick();
    chk_cnt("rel0", 31, 0, 1);
    chk("rel0_vld", 64'(v_free_vld[0]), 64'd1);
    chk("rel0_errr", 64'(err_rel), 64'd0);
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd1;
    tick();
    chk_cnt("rel1", 32, 0, 0);

    // alloc on FREE 7, release on RSVD 9
    idle();
    v_free_rdy = 32'h200;
    tick();
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd7;
    rel_vld_0   = 1'b1; rel_idx_0   = 5'd9;
    tick();
    chk("bad_erra", 64'(err_alloc), 64'd1);
    chk("bad_errr", 64'(err_rel), 64'd1);
    chk_cnt("bad", 31, 1, 0);
    chk("bad_vld", 64'(v_free_vld), 64'hFFFF_FDFF);
    idle();
    tick();
    chk("bad_erra_pulse", 64'(err_alloc), 64'd0);
    chk("bad_errr_pulse", 64'(err_rel), 64'd0);
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd9;
    tick();
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd9;
    tick();
    chk_cnt("clean9", 32, 0, 0);

    // duplicate release on busy 5
    idle();
    v_free_rdy = 32'h20;
    tick();
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd5;
    tick();
    chk_cnt("busy5", 31, 0, 1);
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd5;
    rel_vld_1 = 1'b1; rel_idx_1 = 5'd5;
    tick();
    chk_cnt("duprel", 32, 0, 0);
    chk("duprel_errr", 64'(err_rel), 64'd1);
    chk("duprel_erra", 64'(err_alloc), 64'd0);
    chk("duprel_vld5", 64'(v_free_vld[5]), 64'd1);
    idle();
    tick();
    chk("duprel_pulse", 64'(err_rel), 64'd0);

    // duplicate alloc on reserved 6
    v_free_rdy = 32'h40;
    tick();
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd6;
    alloc_vld_1 = 1'b1; alloc_idx_1 = 5'd6;
    tick();
    chk_cnt("dupalloc", 31, 0, 1);
    chk("dupalloc_erra", 64'(err_alloc), 64'd1);
    idle();
    rel_vld_1 = 1'b1; rel_idx_1 = 5'd6;
    tick();
    chk_cnt("clean6", 32, 0, 0);
    chk("clean6_erra", 64'(err_alloc), 64'd0);

    // concurrent events on distinct entries; rdy on a RSVD entry is ignored
    idle();
    v_free_rdy = 32'hC;
    tick();
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd2;
    tick();
    chk_cnt("mix_pre", 30, 1, 1);
    idle();
    rel_vld_0   = 1'b1; rel_idx_0   = 5'd2;
    alloc_vld_1 = 1'b1; alloc_idx_1 = 5'd3;
    v_free_rdy  = 32'h18;
    tick();
    chk_cnt("mix", 30, 1, 1);
    chk("mix_vld", 64'(v_free_vld), 64'hFFFF_FFE7);
    chk("mix_erra", 64'(err_alloc), 64'd0);
    chk("mix_errr", 64'(err_rel), 64'd0);
    idle();
    alloc_vld_0 = 1'b1; alloc_idx_0 = 5'd4;
    tick();
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd3;
    rel_vld_1 = 1'b1; rel_idx_1 = 5'd4;
    tick();
    chk_cnt("clean34", 32, 0, 0);

    // take everything
    idle();
    v_free_rdy = '1;
    tick();
    chk_cnt("rsvall", 0, 32, 0);
    chk("rsvall_taken", 64'(all_taken), 64'd1);
    chk("rsvall_vld", 64'(v_free_vld), 64'd0);
    idle();
    for (int k = 0; k < 16; k++) begin
      alloc_vld_0 = 1'b1; alloc_idx_0 = IW'(2 * k);
      alloc_vld_1 = 1'b1; alloc_idx_1 = IW'(2 * k + 1);
      tick();
    end
    chk_cnt("busyall", 0, 0, 32);
    chk("busyall_taken", 64'(all_taken), 64'd1);
    chk("busyall_erra", 64'(err_alloc), 64'd0);
    idle();
    rel_vld_0 = 1'b1; rel_idx_0 = 5'd17;
    tick();
    chk("untaken", 64'(all_taken), 64'd0);
    chk_cnt("untaken", 1, 0, 31);
    chk("untaken_vld", 64'(v_free_vld), 64'h0002_0000);

    // random traffic with an asynchronous reset mid-stream
    for (int c = 0; c < 300; c++) begin
      v_free_rdy  = $urandom;
      alloc_vld_0 = 1'($urandom_range(0, 1)); alloc_idx_0 = IW'($urandom_range(0, 31));
      alloc_vld_1 = 1'($urandom_range(0, 1)); alloc_idx_1 = IW'($urandom_range(0, 31));
      rel_vld_0   = 1'($urandom_range(0, 1)); rel_idx_0   = IW'($urandom_range(0, 31));
      rel_vld_1   = 1'($urandom_range(0, 1)); rel_idx_1   = IW'($urandom_range(0, 31));
      tick();
      chk("rnd_sum", 64'(free_cnt) + 64'(rsvd_cnt) + 64'(busy_cnt), 64'd32);
      chk("rnd_free_pop", 64'(free_cnt), 64'($countones(v_free_vld)));
      chk("rnd_taken", 64'(all_taken), 64'(free_cnt == 0));
      if (c == 150) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        tick();
        chk_reset("midrst_hold");
        rst_n = 1'b1;
      end
    end

    idle();
    tick();
    chk("end_sum", 64'(free_cnt) + 64'(rsvd_cnt) + 64'(busy_cnt), 64'd32);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
